// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-road traffic light scheduler: state codes,
// lamp encodings, config selects and default phase durations.
package semaforo_pkg;

  localparam int unsigned LAMP_W = 3;
  localparam int unsigned SEL_W  = 2;

  localparam int unsigned T_VERDE_DEF   = 2;
  localparam int unsigned T_AMARELO_DEF = 1;
  localparam int unsigned T_LIMPEZA_DEF = 1;
  localparam int unsigned T_PED_DEF     = 3;

  typedef enum logic [2:0] {
    S_AV    = 3'd0,
    S_AA    = 3'd1,
    S_R1    = 3'd2,
    S_BV    = 3'd3,
    S_BA    = 3'd4,
    S_R2    = 3'd5,
    S_PED   = 3'd6,
    S_NOITE = 3'd7
  } estado_t;

  localparam logic [LAMP_W-1:0] VERMELHO = 3'b100;
  localparam logic [LAMP_W-1:0] AMARELO  = 3'b010;
  localparam logic [LAMP_W-1:0] VERDE    = 3'b001;
  localparam logic [LAMP_W-1:0] APAGADO  = 3'b000;

  localparam logic [SEL_W-1:0] SEL_VERDE   = 2'd0;
  localparam logic [SEL_W-1:0] SEL_AMARELO = 2'd1;
  localparam logic [SEL_W-1:0] SEL_LIMPEZA = 2'd2;
  localparam logic [SEL_W-1:0] SEL_PED     = 2'd3;

  typedef struct packed {
    logic [LAMP_W-1:0] a;
    logic [LAMP_W-1:0] b;
    logic              walk;
  } lampadas_t;

  // Lamp pattern for each state; night blinking is applied by the caller.
  function automatic lampadas_t decodifica(estado_t e);
    lampadas_t l;
    l = '{a: VERMELHO, b: VERMELHO, walk: 1'b0};
    case (e)
      S_AV:    l.a = VERDE;
      S_AA:    l.a = AMARELO;
      S_BV:    l.b = VERDE;
      S_BA:    l.b = AMARELO;
      S_PED:   l.walk = 1'b1;
      default: l = '{a: VERMELHO, b: VERMELHO, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/semaforo_temporizador.sv
// Loadable phase down-counter; a duration of N yields exactly N cycles, and 0
// is treated as 1. o_expira_c flags the last cycle of the phase.
module semaforo_temporizador #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_DUR = WIDTH'(1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_dur,
  output logic             o_expira_c
);

  logic [WIDTH-1:0] r_cnt;

  function automatic logic [WIDTH-1:0] carga(logic [WIDTH-1:0] d);
    return (d == '0) ? '0 : d - WIDTH'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= carga(RST_DUR);
    end else if (i_load) begin
      r_cnt <= carga(i_dur);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expira_c = (r_cnt == '0);

endmodule

// File: rtl/semaforo_escalonador.sv
// Two-road + pedestrian phase scheduler with programmable durations.
// Optional night blinking mode enabled by defining SEMAFORO_NOTURNO_EN.
module semaforo_escalonador
  import semaforo_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] T_VERDE   = WIDTH'(T_VERDE_DEF),
  parameter logic [WIDTH-1:0] T_AMARELO = WIDTH'(T_AMARELO_DEF),
  parameter logic [WIDTH-1:0] T_LIMPEZA = WIDTH'(T_LIMPEZA_DEF),
  parameter logic [WIDTH-1:0] T_PED     = WIDTH'(T_PED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bt,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic              noturno,
  output logic [LAMP_W-1:0] A,
  output logic [LAMP_W-1:0] B,
  output logic              walk,
  output logic              ped_pend,
  output logic [2:0]        fase
);

  estado_t          r_estado, w_prox_estado;
  logic             r_proxima_a, w_proxima_a;
  logic             r_ped_pend;
  logic [WIDTH-1:0] r_verde, r_amarelo, r_limpeza, r_ped_dur;
  logic [WIDTH-1:0] w_dur;
  logic             w_expira_c;
  logic             w_troca;
  lampadas_t        r_lamp, w_lamp;

  semaforo_temporizador #(
    .WIDTH  (WIDTH),
    .RST_DUR(T_VERDE)
  ) u_temporizador (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_load    (w_troca),
    .i_dur     (w_dur),
    .o_expira_c(w_expira_c)
  );

  // Next state; r_proxima_a picks the road served after clearance or walk.
  always_comb begin
    w_prox_estado = r_estado;
    w_proxima_a   = r_proxima_a;
    case (r_estado)
      S_AV: if (w_expira_c) w_prox_estado = S_AA;
      S_AA: if (w_expira_c) begin
        w_prox_estado = S_R1;
        w_proxima_a   = 1'b0;
      end
      S_BV: if (w_expira_c) w_prox_estado = S_BA;
      S_BA: if (w_expira_c) begin
        w_prox_estado = S_R2;
        w_proxima_a   = 1'b1;
      end
      S_R1, S_R2: if (w_expira_c) begin
        if (r_ped_pend)       w_prox_estado = S_PED;
        else if (r_proxima_a) w_prox_estado = S_AV;
        else                  w_prox_estado = S_BV;
      end
      S_PED: if (w_expira_c) w_prox_estado = r_proxima_a ? S_AV : S_BV;
      S_NOITE: begin
        w_prox_estado = S_R1;
        w_proxima_a   = 1'b1;
      end
      default: w_prox_estado = S_AV;
    endcase
`ifdef SEMAFORO_NOTURNO_EN
    if (noturno) begin
      w_prox_estado = S_NOITE;
      w_proxima_a   = r_proxima_a;
    end
`endif
  end

  assign w_troca = (w_prox_estado != r_estado);

  // Duration for the phase being entered; reads pre-write register values.
  always_comb begin
    w_dur = r_limpeza;
    case (w_prox_estado)
      S_AV, S_BV: w_dur = r_verde;
      S_AA, S_BA: w_dur = r_amarelo;
      S_PED:      w_dur = r_ped_dur;
      default:    w_dur = r_limpeza;
    endcase
  end

`ifdef SEMAFORO_NOTURNO_EN
  logic r_aceso, w_aceso;

  assign w_aceso = (r_estado != S_NOITE) | ~r_aceso;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_aceso <= 1'b0;
    else      r_aceso <= w_aceso;
  end

  always_comb begin
    w_lamp = decodifica(w_prox_estado);
    if (w_prox_estado == S_NOITE) begin
      w_lamp.a    = w_aceso ? AMARELO : APAGADO;
      w_lamp.b    = w_aceso ? AMARELO : APAGADO;
      w_lamp.walk = 1'b0;
    end
  end
`else
  logic w_unused_noturno;

  assign w_unused_noturno = noturno;
  assign w_lamp           = decodifica(w_prox_estado);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado    <= S_AV;
      r_proxima_a <= 1'b0;
      r_lamp      <= '{a: VERDE, b: VERMELHO, walk: 1'b0};
    end else begin
      r_estado    <= w_prox_estado;
      r_proxima_a <= w_proxima_a;
      r_lamp      <= w_lamp;
    end
  end

  // Request latch: entering the walk phase clears it, beating a same-cycle press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ped_pend <= 1'b0;
    end else if (w_prox_estado == S_PED && r_estado != S_PED) begin
      r_ped_pend <= 1'b0;
    end else if (bt) begin
      r_ped_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_verde   <= T_VERDE;
      r_amarelo <= T_AMARELO;
      r_limpeza <= T_LIMPEZA;
      r_ped_dur <= T_PED;
    end else if (cfg_we) begin
      case (cfg_sel)
        SEL_VERDE:   r_verde   <= cfg_data;
        SEL_AMARELO: r_amarelo <= cfg_data;
        SEL_LIMPEZA: r_limpeza <= cfg_data;
        SEL_PED:     r_ped_dur <= cfg_data;
        default:     r_verde   <= r_verde;
      endcase
    end
  end

  assign A        = r_lamp.a;
  assign B        = r_lamp.b;
  assign walk     = r_lamp.walk;
  assign ped_pend = r_ped_pend;
  assign fase     = r_estado;

endmodule

// File: tb/tb_semaforo_escalonador.sv
// Directed self-checking bench for semaforo_escalonador (default build).
module tb_semaforo_escalonador;

  logic       clk = 1'b0;
  logic       rst;
  logic       bt;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       noturno;
  logic [2:0] A, B;
  logic       walk, ped_pend;
  logic [2:0] fase;

  int n_tests = 0;
  int n_fail  = 0;

  semaforo_escalonador dut (
    .clk     (clk),
    .rst     (rst),
    .bt      (bt),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_data(cfg_data),
    .noturno (noturno),
    .A       (A),
    .B       (B),
    .walk    (walk),
    .ped_pend(ped_pend),
    .fase    (fase)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the cycle-0 sample point, just after reset release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; bt = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0; noturno = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (fase !== 3'd0 || A !== 3'b001 || B !== 3'b100 || walk !== 1'b0 || ped_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: fase=%0d A=%b B=%b walk=%b pend=%b, want 0 001 100 0 0", fase, A, B, walk, ped_pend);
    end
  endtask

  task automatic test_default_cycle();
    logic [2:0] ef [9];
    logic [2:0] ea [9];
    logic [2:0] eb [9];
    ef = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0};
    ea = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    eb = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      n_tests++;
      if (fase !== ef[c] || A !== ea[c] || B !== eb[c] || walk !== 1'b0) begin
        n_fail++;
        $display("FAIL default c%0d: fase=%0d A=%b B=%b walk=%b, want %0d %b %b 0",
                 c, fase, A, B, walk, ef[c], ea[c], eb[c]);
      end
      step();
    end
  endtask

  task automatic test_ped();
    logic [2:0] ef [6];
    logic       ew [6];
    logic       ep [6];
    ef = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd3};
    ew = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ep = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    step();
    bt = 1'b1;
    step();
    bt = 1'b0;
    for (int c = 2; c < 8; c++) begin
      n_tests++;
      if (fase !== ef[c-2] || walk !== ew[c-2] || ped_pend !== ep[c-2] ||
          (walk === 1'b1 && (A !== 3'b100 || B !== 3'b100))) begin
        n_fail++;
        $display("FAIL ped c%0d: fase=%0d walk=%b pend=%b A=%b B=%b, want %0d %b %b",
                 c, fase, walk, ped_pend, A, B, ef[c-2], ew[c-2], ep[c-2]);
      end
      step();
    end
  endtask

  task automatic test_bt_held();
    logic [2:0] ef [13];
    logic       ew [13];
    logic       ep [13];
    ef = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd0};
    ew = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ep = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c >= 2) begin
        n_tests++;
        if (fase !== ef[c-2] || walk !== ew[c-2] || ped_pend !== ep[c-2]) begin
          n_fail++;
          $display("FAIL bt_held c%0d: fase=%0d walk=%b pend=%b, want %0d %b %b",
                   c, fase, walk, ped_pend, ef[c-2], ew[c-2], ep[c-2]);
        end
      end
      bt = (c >= 1 && c <= 6);
      step();
    end
    bt = 1'b0;
  endtask

  task automatic test_cfg_verde();
    logic [2:0] ef [17];
    ef = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
           3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    do_reset();
    for (int c = 0; c < 17; c++) begin
      n_tests++;
      if (fase !== ef[c]) begin
        n_fail++;
        $display("FAIL cfg_verde5 c%0d: fase=%0d, want %0d", c, fase, ef[c]);
      end
      cfg_we = (c == 0); cfg_sel = 2'd0; cfg_data = 8'd5;
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_cfg_same_edge();
    logic [2:0] ef [13];
    ef = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    do_reset();
    for (int c = 0; c < 13; c++) begin
      n_tests++;
      if (fase !== ef[c]) begin
        n_fail++;
        $display("FAIL cfg_same_edge c%0d: fase=%0d, want %0d", c, fase, ef[c]);
      end
      cfg_we = (c == 3); cfg_sel = 2'd0; cfg_data = 8'd4;
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_cfg_zero();
    logic [2:0] ef [9];
    ef = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      n_tests++;
      if (fase !== ef[c]) begin
        n_fail++;
        $display("FAIL cfg_zero c%0d: fase=%0d, want %0d", c, fase, ef[c]);
      end
      cfg_we = (c == 0); cfg_sel = 2'd0; cfg_data = 8'd0;
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [2:0] ef [3];
    ef = '{3'd0, 3'd0, 3'd1};
    do_reset();
    repeat (4) step();
    bt = 1'b1;
    step();
    bt = 1'b0;
    n_tests++;
    if (fase !== 3'd3 || ped_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: fase=%0d pend=%b, want 3 1", fase, ped_pend);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (fase !== 3'd0 || A !== 3'b001 || B !== 3'b100 || walk !== 1'b0 || ped_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: fase=%0d A=%b B=%b walk=%b pend=%b, want 0 001 100 0 0",
               fase, A, B, walk, ped_pend);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (fase !== ef[c]) begin
        n_fail++;
        $display("FAIL async_after c%0d: fase=%0d, want %0d", c, fase, ef[c]);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b0; bt = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0; noturno = 1'b0;
    test_reset();
    test_default_cycle();
    test_ped();
    test_bt_held();
    test_cfg_verde();
    test_cfg_same_edge();
    test_cfg_zero();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/semaforo_escalonador.md
Name: semaforo_escalonador

Overview:
Phase scheduler for a two-road intersection (road A, road B) plus a shared pedestrian crossing. It sequences both light heads through green/yellow/all-red. It latches pedestrian button requests and inserts a walk phase at the next all-red boundary. Phase durations are runtime-programmable through a simple write port and sit between the button debouncer and the lamp drivers.

Parameters:
WIDTH, 8, width of duration registers and phase counter (durations 1..2^WIDTH-1 cycles)
T_VERDE, 8'd2, reset value of green duration
T_AMARELO, 8'd1, reset value of yellow duration
T_LIMPEZA, 8'd1, reset value of all-red clearance duration
T_PED, 8'd3, reset value of pedestrian walk duration

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
bt  in  1  pedestrian request, one-cycle or longer pulse, synchronous to clk
cfg_we  in  1  duration write strobe
cfg_sel  in  2  duration select: 0 verde, 1 amarelo, 2 limpeza, 3 ped
cfg_data  in  WIDTH  duration value to write
noturno  in  1  night-mode request (used only with SEMAFORO_NOTURNO_EN)
A  out  3  road A lamps {vermelho, amarelo, verde}, one-hot
B  out  3  road B lamps, same encoding
walk  out  1  pedestrian walk lamp
ped_pend  out  1  latched pedestrian request awaiting service
fase  out  3  current FSM state code

Behaviour:
- States and codes: S_AV=0 (A=001, B=100), S_AA=1 (A=010, B=100), S_R1=2 (both 100), S_BV=3 (A=100, B=001), S_BA=4 (A=100, B=010), S_R2=5 (both 100), S_PED=6 (both 100, walk=1), S_NOITE=7.
- Transitions on timer expiry: S_AV→S_AA→S_R1→(ped_pend ? S_PED : S_BV). S_BV→S_BA→S_R2→(ped_pend ? S_PED : S_AV). S_PED→ the road not served last (proxima flag set in S_R1/S_R2).
- Timing: on phase entry the counter loads the duration minus 1. Each phase lasts exactly N cycles, where N is the duration register; a value of 0 is treated as 1. Outputs are registered and decoded from the state, so lamps change on the clock edge that enters the state.
- Reset (rst=0, asynchronous): state S_AV, counter loaded with T_VERDE, A=001, B=100, walk=0, ped_pend=0, proxima=B, duration registers set to the parameter values. After release, S_AV lasts T_VERDE cycles.
- ped_pend: set by bt=1 on any cycle. Cleared on the edge entering S_PED. A press on that same cycle is absorbed (clear wins). A press during S_PED sets ped_pend again, and it is served at the next all-red. Repeated presses while pending have no effect.
- Config: cfg_we=1 writes cfg_data to the selected register on the clock edge. The new value takes effect at the next entry to that phase; the running phase is not altered. A write and a phase entry on the same edge: the entry uses the old value.
- Lamp safety invariant: A and B are never both non-red. walk=1 only when A=B=100.

Optional Feature:
SEMAFORO_NOTURNO_EN
- Defined: noturno=1 forces S_NOITE on the next edge from any state. ped_pend is held and the counter is ignored. In S_NOITE, A=B=010 and A=B=000 on alternating cycles, starting lit, with walk=0. When noturno falls, the FSM enters S_R1 with T_LIMPEZA and continues normally; proxima is forced to A, so the next green after clearance is A (or S_PED if pending).
- Not defined: the noturno input is ignored, S_NOITE is unreachable, and the code is unused.

Decomposition:
- Shared package semaforo_pkg holds the state codes, the lamp encodings (VERMELHO=3'b100, AMARELO=3'b010, VERDE=3'b001, APAGADO=3'b000), the cfg_sel codes and the default durations.
- One sub-module, semaforo_temporizador: a loadable down-counter with load value and zero-as-1 handling, and an expira output.
- The FSM, the request latch and the config registers stay in the top module.

Test Plan:
- Defaults, no bt, rst released before edge 0: S_AV on cycles 0-1, S_AA on 2, S_R1 on 3, S_BV on 4-5, S_BA on 6, S_R2 on 7, S_AV again on 8 (8-cycle period); walk stays 0.
- bt pulse at cycle 1: ped_pend=1 from cycle 2. After S_R1 at cycle 3, S_PED runs cycles 4-6 with walk=1 and ped_pend=0, then S_BV at cycle 7.
- bt held high through S_PED: ped_pend re-sets during the walk. The next S_R2 is followed by a second S_PED, then S_AV.
- cfg_we with cfg_sel=0, cfg_data=5 during S_AV: the current green is unchanged (2 cycles). The next S_BV lasts 5 cycles. Writing 0 gives 1-cycle phases.
- rst asserted mid-S_BV: outputs go immediately (asynchronously) to A=001, B=100, walk=0, ped_pend=0. After release, the first S_AV lasts 2 cycles.
- With SEMAFORO_NOTURNO_EN, noturno=1 during S_BV: the next cycle A=B=010, then 000, alternating. When noturno drops: 1 cycle all-red, then S_AV. A pending bt is served first via S_PED.
